// File: rtl/game_screen_sequencer.sv
// game_screen_sequencer: top-level game-flow controller.
// Issues one full-screen or maze draw request at a time and holds it until the
// matching drawer reports done. It gates gameplay on a start-key edge and runs
// the per-game countdown timer.
module game_screen_sequencer #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int GAME_SECONDS = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_key,
    input  logic       player_won,
    input  logic       draw_done,
    input  logic       maze_done,
    output logic       draw_start,
    output logic       draw_clear,
    output logic       draw_winner,
    output logic       draw_gameover,
    output logic       draw_maze,
    output logic       play_enable,
    output logic [6:0] seconds_left,
    output logic [3:0] state
);

    // The prescaler only has to hold CLK_HZ-1. CLK_HZ >= 2 keeps this at 1 bit or more.
    localparam int         PW           = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_RELOAD = PW'(CLK_HZ - 1);
    localparam logic [6:0]    SECS_LOAD    = 7'(GAME_SECONDS);

    typedef enum logic [3:0] {
        IDLE         = 4'd0,
        DRAW_START   = 4'd1,
        WAIT_START   = 4'd2,
        DRAW_CLEAR   = 4'd3,
        DRAW_MAZE    = 4'd4,
        PLAY         = 4'd5,
        DRAW_WIN     = 4'd6,
        DRAW_OVER    = 4'd7,
        WAIT_RESTART = 4'd8
    } state_t;

    state_t         state_q, state_d;
    logic           first_q, first_d;
    logic           key_prev_q, key_prev_d;
    logic [6:0]     seconds_q, seconds_d;
    logic [PW-1:0]  presc_q, presc_d;

    logic start_edge;
    logic done_ok;
    logic maze_ok;
    logic tick;

    // A start edge needs the key high now and low on the previous cycle.
    // Done inputs are trusted only after the first cycle of a state, because the
    // previous request's done may still be asserted.
    always_comb begin
        start_edge = start_key && !key_prev_q;
        done_ok    = draw_done && !first_q;
        maze_ok    = maze_done && !first_q;
        tick       = (presc_q == '0);
    end

    // State register, stale-done guard, key history, and timer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            first_q    <= 1'b1;
            key_prev_q <= 1'b1;
            seconds_q  <= '0;
            presc_q    <= '0;
        end else begin
            state_q    <= state_d;
            first_q    <= first_d;
            key_prev_q <= key_prev_d;
            seconds_q  <= seconds_d;
            presc_q    <= presc_d;
        end
    end

    // Next-state and timer logic. Defaults hold every register.
    always_comb begin
        state_d    = state_q;
        seconds_d  = seconds_q;
        presc_d    = presc_q;
        key_prev_d = start_key;

        unique case (state_q)
            IDLE: state_d = DRAW_START;

            DRAW_START: if (done_ok) state_d = WAIT_START;

            WAIT_START: if (start_edge) state_d = DRAW_CLEAR;

            DRAW_CLEAR: if (done_ok) state_d = DRAW_MAZE;

            DRAW_MAZE: begin
                if (maze_ok) begin
                    state_d   = PLAY;
                    seconds_d = SECS_LOAD;
                    presc_d   = PRESC_RELOAD;
                end
            end

            PLAY: begin
                // A win beats a simultaneous final tick, and the count is left untouched.
                if (player_won) begin
                    state_d = DRAW_WIN;
                end else if (tick) begin
                    presc_d   = PRESC_RELOAD;
                    seconds_d = seconds_q - 7'd1;
                    if (seconds_q == 7'd1) state_d = DRAW_OVER;
                end else begin
                    presc_d = presc_q - 1'b1;
                end
            end

            DRAW_WIN:  if (done_ok) state_d = WAIT_RESTART;
            DRAW_OVER: if (done_ok) state_d = WAIT_RESTART;

            WAIT_RESTART: if (start_edge) state_d = DRAW_START;

            default: state_d = IDLE;
        endcase

        first_d = (state_d != state_q);
    end

    // Moore decode of requests and status from the state register only.
    always_comb begin
        draw_start    = (state_q == DRAW_START);
        draw_clear    = (state_q == DRAW_CLEAR);
        draw_maze     = (state_q == DRAW_MAZE);
        draw_winner   = (state_q == DRAW_WIN);
        draw_gameover = (state_q == DRAW_OVER);
        play_enable   = (state_q == PLAY);
        seconds_left  = seconds_q;
        state         = state_q;
    end

endmodule

// File: tb/tb_game_screen_sequencer.sv
// Directed testbench for game_screen_sequencer with CLK_HZ=4 and GAME_SECONDS=3.
module tb_game_screen_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_key;
    logic       player_won;
    logic       draw_done;
    logic       maze_done;
    logic       draw_start, draw_clear, draw_winner, draw_gameover, draw_maze;
    logic       play_enable;
    logic [6:0] seconds_left;
    logic [3:0] state;

    int total = 0;
    int bad   = 0;

    game_screen_sequencer #(.CLK_HZ(4), .GAME_SECONDS(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .start_key    (start_key),
        .player_won   (player_won),
        .draw_done    (draw_done),
        .maze_done    (maze_done),
        .draw_start   (draw_start),
        .draw_clear   (draw_clear),
        .draw_winner  (draw_winner),
        .draw_gameover(draw_gameover),
        .draw_maze    (draw_maze),
        .play_enable  (play_enable),
        .seconds_left (seconds_left),
        .state        (state)
    );

    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start_key = 1'b0; player_won = 1'b0;
        draw_done = 1'b0; maze_done = 1'b0;
        step(); step();
        total++;
        if (state !== 4'd0 || {draw_start, draw_clear, draw_maze, draw_winner, draw_gameover} !== 5'b0
            || play_enable !== 1'b0 || seconds_left !== 7'd0) begin
            bad++;
            $display("FAIL reset_values: state=%0d req=%b play=%b secs=%0d, want 0/00000/0/0",
                     state, {draw_start, draw_clear, draw_maze, draw_winner, draw_gameover},
                     play_enable, seconds_left);
        end
        else $display("reset_values ok");
        reset = 1'b0;
        begin
            int n = 0;
            while (state !== 4'd1 && n < 3) begin step(); n++; end
        end
        total++;
        if (state !== 4'd1 || draw_start !== 1'b1) begin
            bad++;
            $display("FAIL reset_to_draw_start: state=%0d draw_start=%b, want 1/1", state, draw_start);
        end
        else $display("reset_to_draw_start ok");
    endtask

    task automatic test_draw_handshake();
        step(); step(); step();
        total++;
        if (state !== 4'd1 || draw_start !== 1'b1) begin
            bad++;
            $display("FAIL start_held: state=%0d draw_start=%b, want 1/1", state, draw_start);
        end
        else $display("start_held ok");
        draw_done = 1'b1;
        step();
        total++;
        if (state !== 4'd2 || draw_start !== 1'b0) begin
            bad++;
            $display("FAIL start_done: state=%0d draw_start=%b, want 2/0", state, draw_start);
        end
        else $display("start_done ok");
    endtask

    // draw_done stays high from WAIT_START into DRAW_CLEAR.
    task automatic test_stale_done();
        int clear_cycles = 0;
        step(); step();
        start_key = 1'b1;
        step();
        while (draw_clear === 1'b1 && clear_cycles < 10) begin
            clear_cycles++;
            step();
        end
        start_key = 1'b0;
        total++;
        if (clear_cycles != 2 || state !== 4'd4) begin
            bad++;
            $display("FAIL stale_done: clear_cycles=%0d state=%0d, want 2/4", clear_cycles, state);
        end
        else $display("stale_done ok");
        draw_done = 1'b0;
    endtask

    task automatic test_timeout();
        maze_done = 1'b1;
        step();
        step();
        maze_done = 1'b0;
        total++;
        if (state !== 4'd5 || seconds_left !== 7'd3 || play_enable !== 1'b1) begin
            bad++;
            $display("FAIL play_entry: state=%0d secs=%0d play=%b, want 5/3/1", state, seconds_left, play_enable);
        end
        else $display("play_entry ok");
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 3 || k == 4 || k == 8) begin
                logic [6:0] want;
                want = (k == 3) ? 7'd3 : (k == 4) ? 7'd2 : 7'd1;
                total++;
                if (seconds_left !== want || state !== 4'd5) begin
                    bad++;
                    $display("FAIL countdown_k%0d: secs=%0d state=%0d, want %0d/5", k, seconds_left, state, want);
                end
                else $display("countdown_k%0d ok", k);
            end
        end
        total++;
        if (state !== 4'd7 || seconds_left !== 7'd0 || draw_gameover !== 1'b1 || play_enable !== 1'b0) begin
            bad++;
            $display("FAIL timeout: state=%0d secs=%0d over=%b play=%b, want 7/0/1/0",
                     state, seconds_left, draw_gameover, play_enable);
        end
        else $display("timeout ok");
        draw_done = 1'b1;
        step();
        total++;
        if (state !== 4'd7) begin
            bad++;
            $display("FAIL over_first_cycle: state=%0d, want 7", state);
        end
        else $display("over_first_cycle ok");
        step();
        draw_done = 1'b0;
        total++;
        if (state !== 4'd8 || draw_gameover !== 1'b0) begin
            bad++;
            $display("FAIL over_done: state=%0d over=%b, want 8/0", state, draw_gameover);
        end
        else $display("over_done ok");
    endtask

    // Restart from WAIT_RESTART, then run a second game into PLAY.
    task automatic test_restart_to_play();
        start_key = 1'b1;
        step();
        start_key = 1'b0;
        total++;
        if (state !== 4'd1 || draw_start !== 1'b1) begin
            bad++;
            $display("FAIL restart: state=%0d draw_start=%b, want 1/1", state, draw_start);
        end
        else $display("restart ok");
        draw_done = 1'b1;
        step(); step();
        draw_done = 1'b0;
        step();
        start_key = 1'b1;
        step();
        start_key = 1'b0;
        draw_done = 1'b1;
        step(); step();
        draw_done = 1'b0;
        maze_done = 1'b1;
        step(); step();
        maze_done = 1'b0;
        total++;
        if (state !== 4'd5 || seconds_left !== 7'd3) begin
            bad++;
            $display("FAIL second_play: state=%0d secs=%0d, want 5/3", state, seconds_left);
        end
        else $display("second_play ok");
    endtask

    task automatic test_win_tie();
        logic saw_over = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            step();
            if (draw_gameover === 1'b1) saw_over = 1'b1;
        end
        player_won = 1'b1;
        step();
        player_won = 1'b0;
        if (draw_gameover === 1'b1) saw_over = 1'b1;
        total++;
        if (state !== 4'd6 || seconds_left !== 7'd1 || draw_winner !== 1'b1 || saw_over !== 1'b0) begin
            bad++;
            $display("FAIL win_tie: state=%0d secs=%0d win=%b saw_over=%b, want 6/1/1/0",
                     state, seconds_left, draw_winner, saw_over);
        end
        else $display("win_tie ok");
        // A press during DRAW_WIN is held across the move into WAIT_RESTART.
        start_key = 1'b1;
        draw_done = 1'b1;
        step(); step();
        draw_done = 1'b0;
        step(); step(); step();
        total++;
        if (state !== 4'd8 || seconds_left !== 7'd1) begin
            bad++;
            $display("FAIL press_during_win: state=%0d secs=%0d, want 8/1", state, seconds_left);
        end
        else $display("press_during_win ok");
        start_key = 1'b0;
    endtask

    task automatic test_key_through_reset();
        reset = 1'b1;
        start_key = 1'b1;
        step();
        reset = 1'b0;
        draw_done = 1'b1;
        begin
            int n = 0;
            while (state !== 4'd2 && n < 8) begin step(); n++; end
        end
        draw_done = 1'b0;
        step(); step(); step();
        total++;
        if (state !== 4'd2) begin
            bad++;
            $display("FAIL key_held_reset: state=%0d, want 2", state);
        end
        else $display("key_held_reset ok");
        start_key = 1'b0;
        step();
        start_key = 1'b1;
        step();
        start_key = 1'b0;
        total++;
        if (state !== 4'd3 || draw_clear !== 1'b1) begin
            bad++;
            $display("FAIL key_repress: state=%0d clear=%b, want 3/1", state, draw_clear);
        end
        else $display("key_repress ok");
    endtask

    task automatic test_mid_draw_reset();
        draw_done = 1'b1;
        step(); step();
        draw_done = 1'b0;
        total++;
        if (state !== 4'd4 || draw_maze !== 1'b1) begin
            bad++;
            $display("FAIL reach_maze: state=%0d maze=%b, want 4/1", state, draw_maze);
        end
        else $display("reach_maze ok");
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (state !== 4'd0 || draw_maze !== 1'b0 || seconds_left !== 7'd0) begin
            bad++;
            $display("FAIL async_reset: state=%0d maze=%b secs=%0d, want 0/0/0", state, draw_maze, seconds_left);
        end
        else $display("async_reset ok");
        step();
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_draw_handshake();
        test_stale_done();
        test_timeout();
        test_restart_to_play();
        test_win_tie();
        test_key_through_reset();
        test_mid_draw_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case the sequence above stalls.
    initial begin
        #100000;
        $display("FAIL watchdog: sim time limit reached, want finish earlier");
        $fatal(1, "watchdog");
    end

endmodule
